instruction_memory_loader: RTL and testbench
============================================

// Module: instruction_memory_loader
// PURPOSE
// - Writer side of the instruction memory port. The core only reads this memory (write_enable tied 0).
// - Takes a byte stream from a debug/boot link (valid/ready), packs bytes into 32-bit little-endian words
//   and writes them to sequential word addresses starting at 0.
// - Holds the core while loading; releases it when the program is complete.
// PARAMETERS
// - memory_size          1024                     instruction memory size in bytes
// - memory_address_bits  $clog2(memory_size)      byte address width; word address = [memory_address_bits-1:2]
// PORTS
// - clk               in   1                        system clock, rising edge
// - rst_n             in   1                        asynchronous, active-low reset
// - start             in   1                        begin a load (honoured in IDLE or DONE only)
// - byte_valid        in   1                        stream byte present
// - byte_data         in   8                        stream byte
// - byte_last         in   1                        qualifies byte_data as final program byte
// - byte_ready        out  1                        loader accepts byte this cycle
// - mem_write_enable  out  1                        instruction memory write strobe
// - mem_read_enable   out  1                        0 while busy, 1 otherwise (core fetch allowed)
// - mem_address       out  memory_address_bits-2    word address
// - mem_write_data    out  32                       packed word
// - core_hold         out  1                        1 while busy; core kept in reset/stall
// - busy              out  1                        FSM not in IDLE/DONE
// - done              out  1                        sticky until next accepted start
// - overflow_error    out  1                        program longer than memory; sticky until start
// - chk_error         out  1                        checksum mismatch (see CONFIGURATION); sticky until start
// BEHAVIOUR
// - Reset: FSM=IDLE; all outputs 0 except mem_read_enable=1. Word buffer, counters, checksum cleared.
// - States: IDLE, RECV, WRITE, CHECK (macro only), DONE.
// - IDLE/DONE: byte_ready=0. start -> RECV; clears word_addr, byte_cnt, buffer, done, errors, checksum.
// - RECV: byte_ready=1. Handshake = byte_valid & byte_ready. Accepted byte goes to lane byte_cnt
//   (lane 0 = bits[7:0]); byte_cnt++ (2 bits, wraps).
//   -> WRITE when byte_cnt==3 or byte_last. On byte_last, unfilled upper lanes are 0.
// - WRITE: exactly one cycle. byte_ready=0, mem_write_enable=1, mem_address=word_addr, mem_write_data=buffer.
//   Next cycle: buffer cleared, byte_cnt=0.
//   - If last seen: -> CHECK (macro) or DONE.
//   - Else if word_addr==max (2^(memory_address_bits-2)-1): overflow_error=1 -> DONE.
//   - Else: word_addr++ -> RECV.
// - Throughput: 4 accepted bytes + 1 write cycle per word; min 5 cycles/word.
// - mem_write_enable is never high outside WRITE. mem_address holds its last value otherwise.
// - start while busy: ignored.
// - byte_valid outside RECV: not accepted (ready=0); byte stays pending at source.
// - byte_last with byte_cnt==0 still writes one word.
// - rst_n low mid-load: immediate return to reset state. Partial word is not written.
// - done, busy, core_hold are mutually consistent: core_hold==busy; done=1 only in DONE.
// CONFIGURATION
// - IMEM_LOADER_CHECKSUM_EN defined:
//   - 8-bit running sum (mod 256) of all accepted program bytes.
//   - After the last word's WRITE, FSM enters CHECK with byte_ready=1.
//   - The next accepted byte is the expected checksum; its byte_last is ignored.
//   - Mismatch sets chk_error=1. -> DONE in both cases.
// - IMEM_LOADER_CHECKSUM_EN not defined: no CHECK state, no sum register; chk_error tied 0; WRITE -> DONE.
// TESTING
// - Reset: rst_n=0 -> all outputs 0, mem_read_enable=1.
//   start with no bytes -> busy=1, byte_ready=1, no writes.
// - Full words: bytes 13,00,00,00,93,00,10,00 (last on final byte)
//   -> writes 0x00000013 at addr 0, then 0x00100093 at addr 1; done=1; core_hold=0.
// - Partial word: bytes AA,BB,CC (last on CC) -> single write 0x00CCBBAA at addr 0.
//   Write strobe exactly 1 cycle.
// - Backpressure/gaps: random byte_valid gaps on 8-byte stream.
//   -> identical writes; ready=0 during WRITE; no byte lost or duplicated.
// - Overflow, memory_size=16: 20 bytes without last
//   -> 4 writes addr 0..3, overflow_error=1, done=1, 5th word not written, byte_ready=0.
// - Reset/start edge cases:
//   - rst_n pulse after 2 bytes -> no write, IDLE.
//   - start during RECV -> ignored.
// - Checksum (macro): bytes 01,02,03,04(last),0A -> write 0x04030201, chk_error=0.
//   Same stream with checksum 0B -> chk_error=1.

Source files
------------

// File: rtl/instruction_memory_loader_if.sv
`default_nettype none
// ============================================================================
// Interface : instruction_memory_loader_if
// Byte-stream handshake and instruction-memory write port of the program loader.
// Revision  : 1.0
// ============================================================================
interface instruction_memory_loader_if #(
    parameter int WORD_ADDR_BITS = 8
) ();
    logic                      byte_valid;
    logic [7:0]                byte_data;
    logic                      byte_last;
    logic                      byte_ready;
    logic                      mem_write_enable;
    logic                      mem_read_enable;
    logic [WORD_ADDR_BITS-1:0] mem_address;
    logic [31:0]               mem_write_data;

    modport master (
        output byte_valid, byte_data, byte_last,
        input  byte_ready, mem_write_enable, mem_read_enable, mem_address, mem_write_data
    );

    modport slave (
        input  byte_valid, byte_data, byte_last,
        output byte_ready, mem_write_enable, mem_read_enable, mem_address, mem_write_data
    );
endinterface
`default_nettype wire

// File: rtl/instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : instruction_memory_loader
// Packs a boot byte stream into little-endian 32-bit words, writes them to
// sequential instruction-memory word addresses and holds the core meanwhile.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
// Revision : 1.0
// ============================================================================
module instruction_memory_loader #(
    parameter int MEMORY_SIZE         = 1024,
    parameter int MEMORY_ADDRESS_BITS = $clog2(MEMORY_SIZE)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        start,
    instruction_memory_loader_if.slave  bus,
    output logic                        core_hold,
    output logic                        busy,
    output logic                        done,
    output logic                        overflow_error,
    output logic                        chk_error
);

    localparam int                     c_word_bits = MEMORY_ADDRESS_BITS - 2;
    localparam logic [c_word_bits-1:0] c_word_max  = '1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RECV  = 3'd1,
        S_WRITE = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK = 3'd3,
`endif
        S_DONE  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [c_word_bits-1:0] r_word_addr;
    logic [c_word_bits-1:0] r_addr_hold;
    logic [1:0]             r_byte_cnt;
    logic [31:0]            r_buffer;
    logic                   r_last;
    logic                   r_overflow;
    logic                   w_byte_ready;
    logic                   w_write_en;
    logic                   w_accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]             r_sum;
    logic                   r_chk_error;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_byte_ready = 1'b0;
        w_write_en   = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_next_state = S_RECV;
                end
            end
            S_RECV: begin
                w_byte_ready = 1'b1;
                if (bus.byte_valid && (r_byte_cnt == 2'd3 || bus.byte_last)) begin
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_write_en = 1'b1;
                if (r_last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    w_next_state = S_CHECK;
`else
                    w_next_state = S_DONE;
`endif
                end else if (r_word_addr == c_word_max) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_RECV;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CHECK: begin
                w_byte_ready = 1'b1;
                if (bus.byte_valid) begin
                    w_next_state = S_DONE;
                end
            end
`endif
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_accept = bus.byte_valid & w_byte_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_addr <= '0;
            r_addr_hold <= '0;
            r_byte_cnt  <= 2'd0;
            r_buffer    <= 32'd0;
            r_last      <= 1'b0;
            r_overflow  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_sum       <= 8'd0;
            r_chk_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_word_addr <= '0;
                        r_byte_cnt  <= 2'd0;
                        r_buffer    <= 32'd0;
                        r_last      <= 1'b0;
                        r_overflow  <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum       <= 8'd0;
                        r_chk_error <= 1'b0;
`endif
                    end
                end
                S_RECV: begin
                    if (w_accept) begin
                        // Lanes above the last byte stay zero because the buffer is cleared per word
                        r_buffer[{r_byte_cnt, 3'b000} +: 8] <= bus.byte_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        r_last     <= bus.byte_last;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        r_sum      <= r_sum + bus.byte_data;
`endif
                    end
                end
                S_WRITE: begin
                    r_buffer    <= 32'd0;
                    r_byte_cnt  <= 2'd0;
                    r_addr_hold <= r_word_addr;
                    if (!r_last) begin
                        if (r_word_addr == c_word_max) begin
                            r_overflow <= 1'b1;
                        end else begin
                            r_word_addr <= r_word_addr + 1'b1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (w_accept) begin
                        r_chk_error <= (bus.byte_data != r_sum);
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy                 = (r_state != S_IDLE) && (r_state != S_DONE);
    assign core_hold            = busy;
    assign done                 = (r_state == S_DONE);
    assign overflow_error       = r_overflow;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign chk_error            = r_chk_error;
`else
    assign chk_error            = 1'b0;
`endif

    // Address follows the live word pointer only while writing, otherwise it parks
    assign bus.byte_ready       = w_byte_ready;
    assign bus.mem_write_enable = w_write_en;
    assign bus.mem_read_enable  = ~busy;
    assign bus.mem_address      = w_write_en ? r_word_addr : r_addr_hold;
    assign bus.mem_write_data   = r_buffer;

endmodule
`default_nettype wire

// File: tb/tb_instruction_memory_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_instruction_memory_loader
// Scoreboard bench: directed byte streams, expected writes queued, monitors compare.
// Revision : 1.0
// ============================================================================
module tb_instruction_memory_loader;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b1;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic       s_valid0 = 1'b0, s_last0 = 1'b0, s_valid1 = 1'b0, s_last1 = 1'b0;
    logic [7:0] s_data0 = 8'h00, s_data1 = 8'h00;
    logic       hold0, busy0, done0, ovf0, chk0;
    logic       hold1, busy1, done1, ovf1, chk1;

    int n_vec = 0;
    int n_err = 0;
    logic [63:0] exp0[$];
    logic [63:0] exp1[$];
    bit prev_we0 = 1'b0, prev_we1 = 1'b0;

    instruction_memory_loader_if #(.WORD_ADDR_BITS(8)) bus0 ();
    instruction_memory_loader_if #(.WORD_ADDR_BITS(2)) bus1 ();

    assign bus0.byte_valid = s_valid0;
    assign bus0.byte_data  = s_data0;
    assign bus0.byte_last  = s_last0;
    assign bus1.byte_valid = s_valid1;
    assign bus1.byte_data  = s_data1;
    assign bus1.byte_last  = s_last1;

    instruction_memory_loader #(.MEMORY_SIZE(1024)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .bus(bus0),
        .core_hold(hold0), .busy(busy0), .done(done0),
        .overflow_error(ovf0), .chk_error(chk0)
    );

    instruction_memory_loader #(.MEMORY_SIZE(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .bus(bus1),
        .core_hold(hold1), .busy(busy1), .done(done1),
        .overflow_error(ovf1), .chk_error(chk1)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // {byte_ready, write_enable, read_enable, core_hold, busy, done, overflow, chk_error}
    function automatic logic [7:0] st(input int sel);
        if (sel == 0)
            return {bus0.byte_ready, bus0.mem_write_enable, bus0.mem_read_enable,
                    hold0, busy0, done0, ovf0, chk0};
        return {bus1.byte_ready, bus1.mem_write_enable, bus1.mem_read_enable,
                hold1, busy1, done1, ovf1, chk1};
    endfunction

    function automatic logic rdy(input int sel);
        return (sel == 0) ? bus0.byte_ready : bus1.byte_ready;
    endfunction

    task automatic drive(input int sel, input logic v, input logic [7:0] d, input logic l);
        if (sel == 0) begin
            s_valid0 = v; s_data0 = d; s_last0 = l;
        end else begin
            s_valid1 = v; s_data1 = d; s_last1 = l;
        end
    endtask

    task automatic mon_write(input int sel, input logic [31:0] addr, input logic [31:0] data,
                             input logic ready, input bit prev_we);
        logic [63:0] e;
        n_vec++;
        if ((sel == 0 && exp0.size() == 0) || (sel == 1 && exp1.size() == 0)) begin
            n_err++;
            $display("FAIL write%0d_unexpected: got addr %0d data %h expected no write", sel, addr, data);
        end else begin
            e = (sel == 0) ? exp0.pop_front() : exp1.pop_front();
            if ({addr, data} !== e) begin
                n_err++;
                $display("FAIL write%0d: got addr %0d data %h expected addr %0d data %h",
                         sel, addr, data, e[63:32], e[31:0]);
            end
        end
        check($sformatf("ready_in_write%0d", sel), {63'd0, ready}, 64'd0);
        check($sformatf("strobe_width%0d", sel), {63'd0, prev_we}, 64'd0);
    endtask

    always @(negedge clk) begin
        if (bus0.mem_write_enable)
            mon_write(0, 32'(bus0.mem_address), bus0.mem_write_data, bus0.byte_ready, prev_we0);
        if (bus1.mem_write_enable)
            mon_write(1, 32'(bus1.mem_address), bus1.mem_write_data, bus1.byte_ready, prev_we1);
        prev_we0 = bus0.mem_write_enable;
        prev_we1 = bus1.mem_write_enable;
    end

    task automatic offer(input int sel, input logic [7:0] d, input logic l, input int gap,
                         input int bound, output bit ok);
        int t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        drive(sel, 1'b1, d, l);
        while (!rdy(sel) && t < bound) begin
            @(negedge clk);
            t++;
        end
        ok = rdy(sel);
        if (ok) @(posedge clk);
        #1 drive(sel, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input logic l, input int gap);
        bit ok;
        offer(sel, d, l, gap, 50, ok);
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL accept_timeout%0d: byte %h not accepted within 50 cycles", sel, d);
        end
    endtask

    task automatic pulse_start(input int sel);
        @(negedge clk);
        if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
    endtask

    task automatic wait_done(input int sel);
        int t = 0;
        @(negedge clk);
        while (((sel == 0) ? busy0 : busy1) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            n_vec++;
            n_err++;
            $display("FAIL done_timeout%0d: busy still 1 after 100 cycles", sel);
        end
    endtask

    task automatic finish_chk(input int sel, input logic [7:0] sum);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send(sel, sum, 1'b1, 0);
`else
        if (sum == 8'hxx) $display("checksum byte %h", sum);
`endif
    endtask

    localparam int c_n8 = 8;
    logic [7:0] c_stream [c_n8] = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    int         c_gaps   [c_n8] = '{0, 3, 1, 0, 2, 5, 0, 1};

    initial begin
        bit ok;
        #2 rst_n = 1'b0;
        #1;
        check("reset_status0", st(0), 8'b0010_0000);
        check("reset_status1", st(1), 8'b0010_0000);
        check("reset_addr_data0", {24'd0, bus0.mem_address, bus0.mem_write_data}, 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Start with no bytes, then full words with a start pulse mid-load
        pulse_start(0);
        repeat (3) @(negedge clk);
        check("start_no_bytes", st(0), 8'b1001_1000);
        exp0.push_back({32'd0, 32'h0000_0013});
        exp0.push_back({32'd1, 32'h0010_0093});
        send(0, 8'h13, 1'b0, 0);
        send(0, 8'h00, 1'b0, 0);
        pulse_start(0);
        for (int i = 2; i < c_n8; i++) send(0, c_stream[i], (i == c_n8 - 1), 0);
        finish_chk(0, 8'hB6);
        wait_done(0);
        check("full_done_status", st(0), 8'b0010_0100);
        check("full_addr_hold", {56'd0, bus0.mem_address}, 64'd1);
        check("full_queue_empty", 64'(exp0.size()), 64'd0);

        // Partial word
        pulse_start(0);
        exp0.push_back({32'd0, 32'h00CC_BBAA});
        send(0, 8'hAA, 1'b0, 0);
        send(0, 8'hBB, 1'b0, 0);
        send(0, 8'hCC, 1'b1, 0);
        finish_chk(0, 8'h31);
        wait_done(0);
        check("partial_done_status", st(0), 8'b0010_0100);
        check("partial_queue_empty", 64'(exp0.size()), 64'd0);

        // Gapped stream must produce identical writes
        pulse_start(0);
        exp0.push_back({32'd0, 32'h0000_0013});
        exp0.push_back({32'd1, 32'h0010_0093});
        for (int i = 0; i < c_n8; i++) send(0, c_stream[i], (i == c_n8 - 1), c_gaps[i]);
        finish_chk(0, 8'hB6);
        wait_done(0);
        check("gaps_done_status", st(0), 8'b0010_0100);
        check("gaps_queue_empty", 64'(exp0.size()), 64'd0);

        // Byte pending while DONE is held, then last arrives with an empty word
        @(negedge clk);
        drive(0, 1'b1, 8'h11, 1'b0);
        repeat (3) @(negedge clk);
        check("ready_while_done", {63'd0, bus0.byte_ready}, 64'd0);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        check("ready_in_recv", {63'd0, bus0.byte_ready}, 64'd1);
        @(posedge clk);
        #1 drive(0, 1'b0, 8'h00, 1'b0);
        exp0.push_back({32'd0, 32'h4433_2211});
        exp0.push_back({32'd1, 32'h0000_0055});
        send(0, 8'h22, 1'b0, 0);
        send(0, 8'h33, 1'b0, 0);
        send(0, 8'h44, 1'b0, 0);
        send(0, 8'h55, 1'b1, 0);
        finish_chk(0, 8'hFF);
        wait_done(0);
        check("last_cnt0_status", st(0), 8'b0010_0100);
        check("last_cnt0_queue_empty", 64'(exp0.size()), 64'd0);

        // Overflow on the 16-byte instance
        pulse_start(1);
        for (int w = 0; w < 4; w++) begin
            exp1.push_back({32'(w), 8'(4*w+3), 8'(4*w+2), 8'(4*w+1), 8'(4*w)});
        end
        for (int i = 0; i < 16; i++) send(1, 8'(i), 1'b0, 0);
        for (int i = 16; i < 20; i++) begin
            offer(1, 8'(i), 1'b0, 0, 8, ok);
            check("overflow_extra_rejected", {63'd0, ok}, 64'd0);
        end
        wait_done(1);
        check("overflow_status", st(1), 8'b0010_0110);
        check("overflow_queue_empty", 64'(exp1.size()), 64'd0);

        // Reset in the middle of a word
        pulse_start(0);
        send(0, 8'h01, 1'b0, 0);
        send(0, 8'h02, 1'b0, 0);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midload_reset_status", st(0), 8'b0010_0000);
        check("midload_reset_data", {32'd0, bus0.mem_write_data}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("after_reset_idle", st(0), 8'b0010_0000);
        check("after_reset_overflow1", st(1), 8'b0010_0000);

`ifdef IMEM_LOADER_CHECKSUM_EN
        pulse_start(0);
        exp0.push_back({32'd0, 32'h0403_0201});
        send(0, 8'h01, 1'b0, 0);
        send(0, 8'h02, 1'b0, 0);
        send(0, 8'h03, 1'b0, 0);
        send(0, 8'h04, 1'b1, 0);
        send(0, 8'h0A, 1'b1, 0);
        wait_done(0);
        check("chk_good_status", st(0), 8'b0010_0100);
        pulse_start(0);
        exp0.push_back({32'd0, 32'h0403_0201});
        send(0, 8'h01, 1'b0, 0);
        send(0, 8'h02, 1'b0, 0);
        send(0, 8'h03, 1'b0, 0);
        send(0, 8'h04, 1'b1, 0);
        send(0, 8'h0B, 1'b0, 0);
        wait_done(0);
        check("chk_bad_status", st(0), 8'b0010_0101);
        pulse_start(0);
        check("chk_cleared_by_start", st(0), 8'b1001_1000);
        check("chk_queue_empty", 64'(exp0.size()), 64'd0);
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
